// File: rtl/spi_pkg.sv
// ============================================================================
// spi_pkg : shared constants, FSM encoding and helpers for the SPI slave port
// Rev 1.0
// ============================================================================
`default_nettype none

package spi_pkg;

   // {CPOL, CPHA}
   localparam logic [1:0] SPI_MODE0 = 2'b00;

   localparam int DEF_DATA_WIDTH  = 32;
   localparam int DEF_SYNC_STAGES = 2;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_SHIFT   = 2'd1,
      ST_DONE    = 2'd2,
      ST_WAIT_CS = 2'd3
   } spi_state_t;

   function automatic int bit_cnt_width(input int data_width);
      return $clog2(data_width + 1);
   endfunction

endpackage

`default_nettype wire

// File: rtl/spi_slave_port_sync_edge.sv
// ============================================================================
// spi_sync_edge : N-stage synchronizer with rise/fall pulses (sync vs. delayed)
// Rev 1.0
// ============================================================================
`default_nettype none

module spi_sync_edge #(
   parameter int   STAGES    = 2,
   parameter logic RESET_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic level,
   output logic rise,
   output logic fall
);

   logic [STAGES-1:0] r_sync;
   logic              r_dly;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_sync <= {STAGES{RESET_VAL}};
         r_dly  <= RESET_VAL;
      end else begin
         r_sync <= {r_sync[STAGES-2:0], din};
         r_dly  <= r_sync[STAGES-1];
      end
   end

   assign level = r_sync[STAGES-1];
   assign rise  =  r_sync[STAGES-1] & ~r_dly;
   assign fall  = ~r_sync[STAGES-1] &  r_dly;

endmodule

`default_nettype wire

// File: rtl/spi_slave_port.sv
// ============================================================================
// spi_slave_port : oversampled mode-0 SPI slave with TX holding reg and RX pulse
// Optional macro SPI_SLAVE_LSB_FIRST_EN selects LSB-first shifting. Rev 1.0
// ============================================================================
`default_nettype none

module spi_slave_port
   import spi_pkg::*;
#(
   parameter int                    DATA_WIDTH  = DEF_DATA_WIDTH,
   parameter int                    SYNC_STAGES = DEF_SYNC_STAGES,
   parameter logic [DATA_WIDTH-1:0] IDLE_TX     = '0
) (
   input  logic                  s00_axi_aclk,
   input  logic                  s00_axi_aresetn,
   input  logic                  SPI_SCLK,
   input  logic                  SPI_CS,
   input  logic                  SPI_MOSI,
   output logic                  SPI_MISO,
   output logic                  SPI_MISO_OE,
   input  logic [DATA_WIDTH-1:0] tx_data,
   input  logic                  tx_valid,
   output logic                  tx_ready,
   output logic [DATA_WIDTH-1:0] rx_data,
   output logic                  rx_valid,
   output logic                  busy,
   output logic                  err_abort,
   output logic                  err_underrun
);

   localparam int                CNT_W       = bit_cnt_width(DATA_WIDTH);
   localparam logic [CNT_W-1:0]  c_frame_len = CNT_W'(DATA_WIDTH);

   // ---------------------------------------------------------------- inputs
   logic w_sclk_level, w_sclk_rise, w_sclk_fall;
   logic w_cs_level, w_cs_rise, w_cs_fall;
   logic w_unused;
   logic [SYNC_STAGES-1:0] r_mosi_sync;

   spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
      .clk   (s00_axi_aclk),
      .rst_n (s00_axi_aresetn),
      .din   (SPI_SCLK),
      .level (w_sclk_level),
      .rise  (w_sclk_rise),
      .fall  (w_sclk_fall)
   );

   spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
      .clk   (s00_axi_aclk),
      .rst_n (s00_axi_aresetn),
      .din   (SPI_CS),
      .level (w_cs_level),
      .rise  (w_cs_rise),
      .fall  (w_cs_fall)
   );

   assign w_unused = w_sclk_level;

   // MOSI only needs its level, aligned with the SCLK sync depth
   always_ff @(posedge s00_axi_aclk) begin
      if (!s00_axi_aresetn) r_mosi_sync <= '0;
      else                  r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], SPI_MOSI};
   end

   // ---------------------------------------------------------------- state
   spi_state_t             r_state, w_state_nxt;
   logic [DATA_WIDTH-1:0]  r_tx_shift, w_tx_shift_nxt;
   logic [DATA_WIDTH-1:0]  r_rx_shift, w_rx_shift_nxt;
   logic [CNT_W-1:0]       r_bit_cnt, w_bit_cnt_nxt;
   logic                   r_miso, w_miso_nxt;
   logic                   r_oe, w_oe_nxt;
   logic                   r_busy, w_busy_nxt;
   logic [DATA_WIDTH-1:0]  r_rx_data, w_rx_data_nxt;
   logic                   r_rx_valid, w_rx_valid_nxt;
   logic                   r_err_abort, w_err_abort_nxt;
   logic                   r_err_underrun, w_err_underrun_nxt;
   logic                   r_hold_full;
   logic [DATA_WIDTH-1:0]  r_hold_data;
   logic                   w_consume;

   logic [DATA_WIDTH-1:0]  w_load_word, w_tx_adv, w_rx_adv;
   logic                   w_load_bit, w_tx_adv_bit;

   assign w_load_word = r_hold_full ? r_hold_data : IDLE_TX;

`ifdef SPI_SLAVE_LSB_FIRST_EN
   assign w_load_bit   = w_load_word[0];
   assign w_tx_adv     = {1'b0, r_tx_shift[DATA_WIDTH-1:1]};
   assign w_tx_adv_bit = w_tx_adv[0];
   assign w_rx_adv     = {r_mosi_sync[SYNC_STAGES-1], r_rx_shift[DATA_WIDTH-1:1]};
`else
   assign w_load_bit   = w_load_word[DATA_WIDTH-1];
   assign w_tx_adv     = {r_tx_shift[DATA_WIDTH-2:0], 1'b0};
   assign w_tx_adv_bit = w_tx_adv[DATA_WIDTH-1];
   assign w_rx_adv     = {r_rx_shift[DATA_WIDTH-2:0], r_mosi_sync[SYNC_STAGES-1]};
`endif

   always_comb begin
      w_state_nxt        = r_state;
      w_tx_shift_nxt     = r_tx_shift;
      w_rx_shift_nxt     = r_rx_shift;
      w_bit_cnt_nxt      = r_bit_cnt;
      w_miso_nxt         = r_miso;
      w_oe_nxt           = r_oe;
      w_busy_nxt         = r_busy;
      w_rx_data_nxt      = r_rx_data;
      w_rx_valid_nxt     = 1'b0;
      w_err_abort_nxt    = 1'b0;
      w_err_underrun_nxt = 1'b0;
      w_consume          = 1'b0;

      case (r_state)
         ST_IDLE: begin
            if (w_cs_fall) begin
               w_state_nxt        = ST_SHIFT;
               w_consume          = 1'b1;
               w_tx_shift_nxt     = w_load_word;
               w_err_underrun_nxt = ~r_hold_full;
               w_busy_nxt         = 1'b1;
               w_oe_nxt           = 1'b1;
               w_miso_nxt         = w_load_bit;
               w_bit_cnt_nxt      = '0;
            end
         end

         ST_SHIFT: begin
            // CS release wins over a coincident SCLK edge
            if (w_cs_rise) begin
               w_state_nxt     = ST_IDLE;
               w_err_abort_nxt = 1'b1;
               w_busy_nxt      = 1'b0;
               w_oe_nxt        = 1'b0;
               w_miso_nxt      = 1'b0;
            end else if (w_sclk_rise) begin
               w_rx_shift_nxt = w_rx_adv;
               w_bit_cnt_nxt  = r_bit_cnt + 1'b1;
               if (w_bit_cnt_nxt == c_frame_len) w_state_nxt = ST_DONE;
            end else if (w_sclk_fall && (r_bit_cnt < c_frame_len)) begin
               w_tx_shift_nxt = w_tx_adv;
               w_miso_nxt     = w_tx_adv_bit;
            end
         end

         ST_DONE: begin
            w_rx_data_nxt  = r_rx_shift;
            w_rx_valid_nxt = 1'b1;
            if (w_cs_level) begin
               w_state_nxt = ST_IDLE;
               w_busy_nxt  = 1'b0;
               w_oe_nxt    = 1'b0;
               w_miso_nxt  = 1'b0;
            end else begin
               w_state_nxt = ST_WAIT_CS;
            end
         end

         ST_WAIT_CS: begin
            if (w_cs_rise) begin
               w_state_nxt = ST_IDLE;
               w_busy_nxt  = 1'b0;
               w_oe_nxt    = 1'b0;
               w_miso_nxt  = 1'b0;
            end
         end

         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge s00_axi_aclk) begin
      if (!s00_axi_aresetn) begin
         r_state        <= ST_IDLE;
         r_tx_shift     <= '0;
         r_rx_shift     <= '0;
         r_bit_cnt      <= '0;
         r_miso         <= 1'b0;
         r_oe           <= 1'b0;
         r_busy         <= 1'b0;
         r_rx_data      <= '0;
         r_rx_valid     <= 1'b0;
         r_err_abort    <= 1'b0;
         r_err_underrun <= 1'b0;
      end else begin
         r_state        <= w_state_nxt;
         r_tx_shift     <= w_tx_shift_nxt;
         r_rx_shift     <= w_rx_shift_nxt;
         r_bit_cnt      <= w_bit_cnt_nxt;
         r_miso         <= w_miso_nxt;
         r_oe           <= w_oe_nxt;
         r_busy         <= w_busy_nxt;
         r_rx_data      <= w_rx_data_nxt;
         r_rx_valid     <= w_rx_valid_nxt;
         r_err_abort    <= w_err_abort_nxt;
         r_err_underrun <= w_err_underrun_nxt;
      end
   end

   // A load coinciding with frame start refills the register for the next frame
   always_ff @(posedge s00_axi_aclk) begin
      if (!s00_axi_aresetn) begin
         r_hold_full <= 1'b0;
         r_hold_data <= '0;
      end else if (tx_valid && !r_hold_full) begin
         r_hold_full <= 1'b1;
         r_hold_data <= tx_data;
      end else if (w_consume) begin
         r_hold_full <= 1'b0;
      end
   end

   assign SPI_MISO     = r_miso;
   assign SPI_MISO_OE  = r_oe;
   assign tx_ready     = ~r_hold_full;
   assign rx_data      = r_rx_data;
   assign rx_valid     = r_rx_valid;
   assign busy         = r_busy;
   assign err_abort    = r_err_abort;
   assign err_underrun = r_err_underrun;

endmodule

`default_nettype wire

// File: tb/tb_spi_slave_port.sv
// ============================================================================
// tb_spi_slave_port : randomized mode-0 master against a word-level slave model
// Rev 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_spi_slave_port;

   localparam int          DW     = 32;
   localparam int          SS     = 2;
   localparam logic [31:0] IDLE_W = 32'h0;
`ifdef SPI_SLAVE_LSB_FIRST_EN
   localparam bit LSB = 1'b1;
`else
   localparam bit LSB = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          sclk = 1'b0, cs = 1'b1, mosi = 1'b0;
   logic          miso, miso_oe;
   logic [DW-1:0] tx_data = '0;
   logic          tx_valid = 1'b0;
   logic          tx_ready;
   logic [DW-1:0] rx_data;
   logic          rx_valid, busy, err_abort, err_underrun;

   always #5 clk = ~clk;

   spi_slave_port #(.DATA_WIDTH(DW), .SYNC_STAGES(SS), .IDLE_TX(IDLE_W)) dut (
      .s00_axi_aclk    (clk),
      .s00_axi_aresetn (rst_n),
      .SPI_SCLK        (sclk),
      .SPI_CS          (cs),
      .SPI_MOSI        (mosi),
      .SPI_MISO        (miso),
      .SPI_MISO_OE     (miso_oe),
      .tx_data         (tx_data),
      .tx_valid        (tx_valid),
      .tx_ready        (tx_ready),
      .rx_data         (rx_data),
      .rx_valid        (rx_valid),
      .busy            (busy),
      .err_abort       (err_abort),
      .err_underrun    (err_underrun)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   // Pulse monitor, sampled on the falling aclk edge
   int  rv_cnt = 0, ab_cnt = 0, ur_cnt = 0;
   int  lat = -1;
   time t_last_rise = 0;
   always @(negedge clk) begin
      if (rx_valid) begin
         rv_cnt++;
         lat = int'(($time - t_last_rise) / 10);
      end
      if (err_abort)    ab_cnt++;
      if (err_underrun) ur_cnt++;
   end

   // Word-level slave model
   bit          m_full = 1'b0;
   logic [31:0] m_hold = '0;
   logic [31:0] m_rx   = '0;

   function automatic logic sbit(input logic [31:0] w, input int i);
      return LSB ? w[i] : w[DW-1-i];
   endfunction

   function automatic logic [31:0] assemble(input logic [63:0] bits);
      logic [31:0] r = '0;
      for (int i = 0; i < DW; i++) r[LSB ? i : DW-1-i] = bits[i];
      return r;
   endfunction

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic push_tx(input logic [31:0] w);
      tx_data  = w;
      tx_valid = 1'b1;
      if (!m_full) begin
         m_full = 1'b1;
         m_hold = w;
      end
      tick(1);
      tx_valid = 1'b0;
      tx_data  = $urandom;
   endtask

   // SCLK = aclk/8: four aclk cycles per half period
   task automatic spi_frame(input int nclk, input logic [31:0] w,
                            output logic [63:0] mb, output logic act);
      mb   = '0;
      act  = 1'b1;
      cs   = 1'b0;
      mosi = sbit(w, 0);
      tick(8);
      for (int i = 0; i < nclk; i++) begin
         mb[i] = miso;
         act   = act & miso_oe & busy;
         sclk  = 1'b1;
         if (i == DW-1) t_last_rise = $time;
         tick(4);
         sclk = 1'b0;
         mosi = (i + 1 < DW) ? sbit(w, i + 1) : 1'($urandom);
         tick(4);
      end
      cs = 1'b1;
      tick(8);
   endtask

   task automatic run_frame(input string tag, input int nclk, input logic [31:0] w);
      logic [31:0] exp_tx;
      bit          exp_ur;
      int          rv0, ab0, ur0;
      logic [63:0] mb;
      logic        act;
      logic [7:0]  xg, xe;
      exp_tx = m_full ? m_hold : IDLE_W;
      exp_ur = !m_full;
      m_full = 1'b0;
      rv0 = rv_cnt; ab0 = ab_cnt; ur0 = ur_cnt; lat = -1;
      spi_frame(nclk, w, mb, act);
      check_val({tag, "_active"}, act, 1);
      check_val({tag, "_underrun"}, ur_cnt - ur0, exp_ur);
      if (nclk >= DW) begin
         m_rx = w;
         check_val({tag, "_rx"}, rx_data, w);
         check_val({tag, "_rxv_cnt"}, rv_cnt - rv0, 1);
         check_val({tag, "_abort_cnt"}, ab_cnt - ab0, 0);
         check_val({tag, "_latency"}, lat, SS + 2);
         check_val({tag, "_miso"}, assemble(mb), exp_tx);
         if (nclk > DW) begin
            xg = '0; xe = '0;
            for (int i = DW; i < nclk; i++) begin
               xg[i-DW] = mb[i];
               xe[i-DW] = sbit(exp_tx, DW-1);
            end
            check_val({tag, "_miso_hold"}, xg, xe);
         end
      end else begin
         check_val({tag, "_rx_kept"}, rx_data, m_rx);
         check_val({tag, "_rxv_cnt"}, rv_cnt - rv0, 0);
         check_val({tag, "_abort_cnt"}, ab_cnt - ab0, 1);
         xg = '0; xe = '0;
         for (int i = 0; i < nclk && i < 8; i++) begin
            xg[i] = mb[i];
            xe[i] = sbit(exp_tx, i);
         end
         check_val({tag, "_miso_part"}, xg, xe);
      end
      check_val({tag, "_tx_ready"}, tx_ready, !m_full);
      check_val({tag, "_idle"}, {busy, miso_oe}, 2'b00);
   endtask

   task automatic check_reset_outputs(input string tag);
      check_val({tag, "_miso"}, miso, 0);
      check_val({tag, "_oe"}, miso_oe, 0);
      check_val({tag, "_tx_ready"}, tx_ready, 1);
      check_val({tag, "_rx_data"}, rx_data, 0);
      check_val({tag, "_pulses"}, {rx_valid, err_abort, err_underrun}, 3'b000);
      check_val({tag, "_busy"}, busy, 0);
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, np;
      logic [63:0] mb;
      logic        act;

      tick(4);
      check_reset_outputs("reset");
      rst_n = 1'b1;
      tick(4);

      push_tx(32'hA5A5_3C3C);
      check_val("load_tx_ready", tx_ready, 0);
      run_frame("basic", 32, 32'h1234_5678);

      run_frame("underrun", 32, $urandom);

      push_tx($urandom);
      run_frame("abort", 17, $urandom);
      run_frame("after_abort", 32, 32'hDEAD_BEEF);

      push_tx($urandom);
      run_frame("long", 40, $urandom);

      // Reset partway through a frame
      push_tx($urandom);
      m_full = 1'b0;
      spi_frame(0, 32'h0, mb, act);
      cs = 1'b0;
      tick(8);
      for (int i = 0; i < 10; i++) begin
         sclk = 1'b1; tick(4);
         sclk = 1'b0; mosi = 1'($urandom); tick(4);
      end
      rst_n = 1'b0;
      cs    = 1'b1;
      tick(1);
      check_reset_outputs("mid_rst");
      m_rx = '0;
      tick(3);
      rst_n = 1'b1;
      tick(4);
      push_tx($urandom);
      run_frame("post_reset", 32, 32'h0F0F_0F0F);

`ifdef SPI_SLAVE_LSB_FIRST_EN
      push_tx(32'h8000_0000);
      run_frame("lsb", 32, 32'h0000_0001);
`endif

      for (int f = 0; f < 12; f++) begin
         np = $urandom_range(0, 2);
         for (int p = 0; p < np; p++) push_tx($urandom);
         case ($urandom_range(0, 4))
            0:       n = $urandom_range(1, DW - 1);
            1:       n = DW + $urandom_range(1, 8);
            default: n = DW;
         endcase
         run_frame($sformatf("rand%0d", f), n, $urandom);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
